// File: rtl/min_max_pkg.sv
// min_max_pkg: shared sizes and one-hot state encoding for the min/max array loader.
package min_max_pkg;
    localparam int N = 16;
    localparam int W = 8;
    localparam int AW = $clog2(N);
    localparam int TIMEOUT = 64;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        FILL  = 5'b00010,
        START = 5'b00100,
        WAIT  = 5'b01000,
        OUT   = 5'b10000
    } state_t;
endpackage

// File: rtl/min_max_regfile.sv
// min_max_regfile: N x W array, one synchronous write port and one combinational read port, no reset.
module min_max_regfile
    import min_max_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/min_max_array_loader.sv
// min_max_array_loader: fills the finder's array from a byte stream, starts the finder,
// waits for Done under a watchdog and holds the captured Max/Min until acknowledged.
module min_max_array_loader
    import min_max_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Load_Req,
    input  logic [W-1:0]  In_Data,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [AW-1:0] Rd_Addr,
    output logic [W-1:0]  Rd_Data,
    output logic          Start,
    input  logic          Done,
    input  logic [W-1:0]  Max_In,
    input  logic [W-1:0]  Min_In,
    output logic [W-1:0]  Max_Out,
    output logic [W-1:0]  Min_Out,
    output logic          Out_Valid,
    input  logic          Out_Ack,
    output logic          Err,
    output logic          Qi,
    output logic          Qf,
    output logic          Qs,
    output logic          Qw,
    output logic          Qo
);
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [W-1:0]  max_q, max_d, min_q, min_d;
    logic          err_q, err_d, we;

    min_max_regfile u_rf (
        .clk(Clk), .we(we), .waddr(wr_ptr_q), .wdata(In_Data),
        .raddr(Rd_Addr), .rdata(Rd_Data)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        tmr_d    = tmr_q;
        max_d    = max_q;
        min_d    = min_q;
        err_d    = err_q;
        we       = 1'b0;
        case (state_q)
            IDLE: if (Load_Req) begin
                state_d  = FILL;
                wr_ptr_d = '0;
                err_d    = 1'b0;
            end
            FILL: if (In_Valid) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = (wr_ptr_q == AW'(N - 1)) ? START : FILL;
            end
            START: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_d = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
                // Done takes priority over a coinciding watchdog expiry
                if (Done) begin
                    max_d   = Max_In;
                    min_d   = Min_In;
                    state_d = OUT;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: if (Out_Ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            tmr_q    <= '0;
            max_q    <= '0;
            min_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            tmr_q    <= tmr_d;
            max_q    <= max_d;
            min_q    <= min_d;
            err_q    <= err_d;
        end
    end

    assign {Qo, Qw, Qs, Qf, Qi} = state_q;
    assign In_Ready  = Qf;
    assign Start     = Qs;
    assign Out_Valid = Qo;
    assign Max_Out   = max_q;
    assign Min_Out   = min_q;
    assign Err       = err_q;
endmodule

// File: tb/tb_min_max_array_loader.sv
// tb_min_max_array_loader: directed vectors; expected results are queued at Done and
// checked by a monitor when Out_Valid rises.
module tb_min_max_array_loader;
    logic       Clk = 1'b0, Reset_n = 1'b0, Load_Req = 1'b0, In_Valid = 1'b0;
    logic       Done = 1'b0, Out_Ack = 1'b0;
    logic [7:0] In_Data = '0, Max_In = '0, Min_In = '0;
    logic [3:0] Rd_Addr = '0;
    logic [7:0] Rd_Data, Max_Out, Min_Out;
    logic       In_Ready, Start, Out_Valid, Err, Qi, Qf, Qs, Qw, Qo;

    int n_vec = 0, n_bad = 0;
    logic [15:0] sb [$];
    logic prev_ov = 1'b0;
    logic [7:0] d [16];

    min_max_array_loader dut (
        .Clk(Clk), .Reset_n(Reset_n), .Load_Req(Load_Req), .In_Data(In_Data),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
        .Start(Start), .Done(Done), .Max_In(Max_In), .Min_In(Min_In),
        .Max_Out(Max_Out), .Min_Out(Min_Out), .Out_Valid(Out_Valid), .Out_Ack(Out_Ack),
        .Err(Err), .Qi(Qi), .Qf(Qf), .Qs(Qs), .Qw(Qw), .Qo(Qo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: one result per rising Out_Valid
    always @(negedge Clk) begin
        if (Out_Valid && !prev_ov) begin
            if (sb.size() == 0) chk("sb_unexpected_out", 32'(Out_Valid), 32'd0);
            else chk("sb_result", {Max_Out, Min_Out}, sb.pop_front());
        end
        prev_ov = Out_Valid;
    end

    task automatic load();
        Load_Req = 1'b1;
        tick();
        Load_Req = 1'b0;
        chk("fill_entered", 32'(Qf), 32'd1);
    endtask

    // Handshake d[0..15]; In_Valid is high on every gap-th cycle only.
    task automatic do_fill(input int gap);
        int k = 0;
        int c = 0;
        while (k < 16) begin
            In_Valid = (c % gap == 0);
            In_Data  = In_Valid ? d[k] : 8'hEE;
            chk("in_ready_fill", 32'(In_Ready), 32'd1);
            tick();
            if (In_Valid) k++;
            c++;
        end
        In_Valid = 1'b0;
        In_Data  = 8'h00;
        chk("start_pulse", 32'(Start), 32'd1);
        chk("in_ready_start", 32'(In_Ready), 32'd0);
    endtask

    task automatic ack();
        Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        chk("ack_idle", 32'(Qi), 32'd1);
        chk("ack_ov_low", 32'(Out_Valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset, straight fill 00..0F
        tick();
        tick();
        chk("rst_qi", 32'(Qi), 32'd1);
        chk("rst_outs", {In_Ready, Start, Out_Valid, Err}, 32'd0);
        chk("rst_res", {Max_Out, Min_Out}, 32'd0);
        Reset_n = 1'b1;
        tick();
        chk("idle_hold", 32'(Qi), 32'd1);
        load();
        for (int i = 0; i < 16; i++) d[i] = 8'(i);
        do_fill(1);
        tick();
        chk("start_one_cycle", {Start, Qw}, 32'd1);
        Rd_Addr = 4'd5;
        #1;
        chk("rd_addr5", Rd_Data, 32'h05);
        // 4: watchdog, no Done
        repeat (63) tick();
        chk("wait_63", {Qw, Err}, 32'b10);
        tick();
        chk("timeout_idle", {Qi, Err, Out_Valid}, 32'b110);
        load();
        chk("err_cleared", 32'(Err), 32'd0);
        // 2: gapped fill, 3: Done on WAIT cycle 20
        for (int i = 0; i < 16; i++) d[i] = 8'(8'h30 + 8'(i * 7));
        do_fill(3);
        tick();
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                Rd_Addr = 4'(c);
                #1;
                chk("gapped_rd", Rd_Data, d[c]);
            end
            tick();
        end
        chk("wait_20", 32'(Qw), 32'd1);
        Done = 1'b1;
        Max_In = 8'hF0;
        Min_In = 8'h03;
        sb.push_back(16'hF003);
        tick();
        Done = 1'b0;
        Max_In = 8'h99;
        Min_In = 8'h88;
        for (int c = 0; c < 5; c++) begin
            Done = c[0];
            Load_Req = ~c[0];
            chk("out_hold", {Out_Valid, Max_Out, Min_Out}, {1'b1, 16'hF003});
            tick();
        end
        Done = 1'b0;
        Load_Req = 1'b0;
        ack();
        // 5: Done exactly on WAIT cycle TIMEOUT-1
        load();
        for (int i = 0; i < 16; i++) d[i] = 8'(8'hFF - 8'(i));
        do_fill(1);
        tick();
        repeat (63) tick();
        chk("wait_63b", {Qw, Err}, 32'b10);
        Done = 1'b1;
        Max_In = 8'h77;
        Min_In = 8'h11;
        sb.push_back(16'h7711);
        tick();
        Done = 1'b0;
        chk("tie_done_wins", {Qo, Err}, 32'b10);
        chk("tie_result", {Max_Out, Min_Out}, 32'h7711);
        ack();
        // 6: reset mid-fill, then a fresh fill from address 0
        load();
        for (int i = 0; i < 7; i++) begin
            In_Valid = 1'b1;
            In_Data = 8'(8'h50 + 8'(i));
            tick();
        end
        In_Valid = 1'b0;
        chk("partial_fill", 32'(Qf), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("midrst_qi", 32'(Qi), 32'd1);
        chk("midrst_outs", {In_Ready, Start, Out_Valid, Err}, 32'd0);
        chk("midrst_res", {Max_Out, Min_Out}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        load();
        for (int i = 0; i < 16; i++) d[i] = 8'(8'hC0 + 8'(i));
        do_fill(1);
        tick();
        Rd_Addr = 4'd0;
        #1;
        chk("refill_addr0", Rd_Data, 32'hC0);
        Rd_Addr = 4'd7;
        #1;
        chk("refill_addr7", Rd_Data, 32'hC7);
        Done = 1'b1;
        Max_In = 8'hCF;
        Min_In = 8'hC0;
        sb.push_back(16'hCFC0);
        tick();
        Done = 1'b0;
        Load_Req = 1'b1;
        tick();
        tick();
        Load_Req = 1'b0;
        chk("loadreq_in_out", {Qo, Qf}, 32'b10);
        ack();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/min_max_array_loader.md
Name: min_max_array_loader

Overview:
- Upstream front-end for the 16-entry min/max finder.
- Accepts a stream of unsigned bytes over a valid/ready handshake and fills an N-entry register array.
- Serves the array to the finder through a combinational read port and issues a one-cycle Start pulse.
- Waits for the finder's Done with a watchdog, then captures Max/Min and holds them under an output valid/ack handshake.

Parameters:
N, 16, number of array elements (power of two; the address is clog2(N) bits)
W, 8, element width in bits (unsigned)
TIMEOUT, 64, maximum number of WAIT cycles before Err is raised

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Load_Req  input  1  request a new fill; sampled in IDLE only
In_Data  input  W  incoming element
In_Valid  input  1  In_Data is valid
In_Ready  output  1  block accepts In_Data (high only in FILL)
Rd_Addr  input  clog2(N)  finder read address
Rd_Data  output  W  array[Rd_Addr], combinational
Start  output  1  one-cycle start pulse to the finder
Done  input  1  finder completion (its Qd)
Max_In  input  W  finder Max result
Min_In  input  W  finder Min result
Max_Out  output  W  captured Max
Min_Out  output  W  captured Min
Out_Valid  output  1  Max_Out/Min_Out are valid
Out_Ack  input  1  consumer acknowledges the result
Err  output  1  watchdog expired (sticky until the next Load_Req)
Qi, Qf, Qs, Qw, Qo  output  1 each  one-hot state bits for IDLE, FILL, START, WAIT, OUT

Behaviour:
- Reset (asynchronous on Reset_n low):
  - State = IDLE; Wr_Ptr = 0; Tmr = 0.
  - Start, In_Ready, Out_Valid and Err = 0; Max_Out and Min_Out = 0.
  - Array contents are not reset.
- State encoding: 5-bit one-hot. {Qo,Qw,Qs,Qf,Qi} = state.
- IDLE:
  - On Load_Req = 1: go to FILL, Wr_Ptr <= 0, Err <= 0.
  - Otherwise stay in IDLE.
- FILL:
  - In_Ready = 1 (combinational from state).
  - A handshake is In_Valid & In_Ready. On each handshake: array[Wr_Ptr] <= In_Data; Wr_Ptr <= Wr_Ptr + 1.
  - A handshake at Wr_Ptr = N-1 moves the block to START. Wr_Ptr wraps to 0.
  - Cycles with In_Valid = 0 write nothing and keep the state.
- START:
  - Start = 1 for exactly this one cycle; Tmr <= 0; go to WAIT unconditionally.
  - Latency: Start is high in the cycle immediately after the Nth handshake edge.
- WAIT:
  - Each cycle Tmr <= Tmr + 1.
  - If Done = 1: Max_Out <= Max_In, Min_Out <= Min_In, go to OUT.
  - Otherwise, if Tmr = TIMEOUT-1: Err <= 1, go to IDLE.
  - If Done and the timeout coincide, Done wins: go to OUT, Err stays 0.
- OUT:
  - Out_Valid = 1; Max_Out and Min_Out are held stable.
  - On Out_Ack = 1: go to IDLE. Out_Valid is low from the next cycle.
- Ignored inputs:
  - Load_Req outside IDLE.
  - Done outside WAIT.
  - Out_Ack outside OUT.
  - In_Valid outside FILL (In_Ready is 0 there).
- Read port: Rd_Data = array[Rd_Addr] in every state. The array holds its contents until they are overwritten during the next FILL.
- Widths:
  - Wr_Ptr is clog2(N) bits and wraps naturally.
  - Tmr is clog2(TIMEOUT)+1 bits and saturates; it is never compared beyond TIMEOUT-1.
- Reset mid-operation (any state): takes effect immediately. Partially written array contents remain, but the next fill restarts at address 0.
- Integration: the finder's reset is active-high. The top level drives it with ~Reset_n.

Decomposition:
- Shared package min_max_pkg holds:
  - N, W and the address width.
  - The state localparams IDLE, FILL, START, WAIT, OUT.
- One natural sub-module, min_max_regfile:
  - N x W array with one synchronous write port (we, waddr, wdata) and one combinational read port.
  - No reset.
- The FSM, Wr_Ptr, the timer and the result registers stay in the top module.

Test Plan:
1. Reset_n low then high; Load_Req pulse; stream bytes 8'h00..8'h0F with In_Valid held high -> In_Ready high for 16 cycles. Start is high for one cycle right after the 16th handshake. Rd_Addr = 5 returns Rd_Data = 8'h05.
2. Fill with In_Valid toggling 1,0,0,1,... -> only the handshaked bytes are stored at consecutive addresses. START is reached only after exactly 16 handshakes; array[15] equals the 16th accepted byte.
3. Done asserted on WAIT cycle 20 with Max_In = 8'hF0, Min_In = 8'h03 -> next cycle Out_Valid = 1, Max_Out = 8'hF0, Min_Out = 8'h03. Values are held for 5 cycles until Out_Ack, then IDLE.
4. Done never asserted, TIMEOUT = 64 -> Err = 1 and Qi = 1 after 64 WAIT cycles; Out_Valid stays 0. The next Load_Req clears Err.
5. Done asserted exactly on WAIT cycle TIMEOUT-1 -> OUT entered, Err = 0, results captured.
6. Reset_n pulsed low after 7 bytes of a fill -> Qi = 1 immediately and all outputs return to reset values. A fresh fill writes its first byte to address 0; Load_Req while in OUT has no effect.
